// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the 8-bit external SRAM bridge.
package mem_bridge_pkg;

    localparam int unsigned WAIT_CTR_W = 4;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned DATA_W     = 16;

    // Value of ext_addr[0] for each byte lane
    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Request fields still needed after capture (be0 only steers the first phase)
    typedef struct packed {
        logic              wr;
        logic              be1;
        logic [DATA_W-1:0] data;
    } req_t;

endpackage

// File: rtl/mem_bridge_wait_ctr.sv
// Strobe wait-state counter: load at phase start, count down to zero, optional ext_rdy stall.
// Optional feature: MEM_BRIDGE_EXT_RDY_EN adds the ext_rdy_i stall input.
module mem_bridge_wait_ctr
    import mem_bridge_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic dec_i,
`ifdef MEM_BRIDGE_EXT_RDY_EN
    input  logic ext_rdy_i,
`endif
    output logic zero_o,
    output logic done_c
);

    logic [WAIT_CTR_W-1:0] count_q, count_d;
    logic                  zero_q;

    // Saturating down-counter; zero flag registered alongside the count
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = WAIT_CTR_W'(WAIT_STATES);
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - WAIT_CTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            zero_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            zero_q  <= (count_d == '0);
        end
    end

    assign zero_o = zero_q;

`ifdef MEM_BRIDGE_EXT_RDY_EN
    assign done_c = zero_q & ext_rdy_i;
`else
    assign done_c = zero_q;
`endif

endmodule

// File: rtl/mem_bridge_8b.sv
// LSU 16-bit byte-enabled request -> one or two byte phases on an 8-bit async SRAM bus.
// Optional feature: MEM_BRIDGE_EXT_RDY_EN adds the ext_rdy input to stretch strobe phases.
module mem_bridge_8b
    import mem_bridge_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              a_rst,
    input  logic              mem_assert,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_cmd,
    input  logic              be0,
    input  logic              be1,
    output logic              mem_rdy,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [BYTE_W-1:0] ext_dout,
    input  logic [BYTE_W-1:0] ext_din,
`ifdef MEM_BRIDGE_EXT_RDY_EN
    input  logic              ext_rdy,
`endif
    output logic              ext_cs_n,
    output logic              ext_oe_n,
    output logic              ext_we_n
);

    state_e            state_q, state_d;
    logic              setup_q, setup_d;
    logic [ADDR_W-2:0] word_q, word_d;
    req_t              req_q, req_d;
    logic              mem_rdy_q, mem_rdy_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [ADDR_W-1:0] ext_addr_q, ext_addr_d;
    logic [BYTE_W-1:0] ext_dout_q, ext_dout_d;
    logic              cs_n_q, cs_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic              ctr_load, ctr_dec, ctr_zero, ctr_done_c;
    logic              phase_d, strobe_d;
    logic              unused_addr_lsb;

    // Lane is chosen by the byte enables, not by the request address LSB
    assign unused_addr_lsb = mem_addr[0];

    mem_bridge_wait_ctr #(
        .WAIT_STATES(WAIT_STATES)
    ) u_wait_ctr (
        .clk      (clk),
        .rst_n    (a_rst),
        .load_i   (ctr_load),
        .dec_i    (ctr_dec),
`ifdef MEM_BRIDGE_EXT_RDY_EN
        .ext_rdy_i(ext_rdy),
`endif
        .zero_o   (ctr_zero),
        .done_c   (ctr_done_c)
    );

    always_comb begin
        state_d    = state_q;
        setup_d    = setup_q;
        word_d     = word_q;
        req_d      = req_q;
        rd_data_d  = rd_data_q;
        ext_addr_d = ext_addr_q;
        ext_dout_d = ext_dout_q;
        ctr_dec    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_assert) begin
                    word_d   = mem_addr[ADDR_W-1:1];
                    req_d.wr   = mem_cmd;
                    req_d.be1  = be1;
                    req_d.data = mem_data;
                    if (!mem_cmd) begin
                        rd_data_d = '0;
                    end
                    state_d = be0 ? S_LO : (be1 ? S_HI : S_DONE);
                    setup_d = be0 | be1;
                end
            end
            S_LO, S_HI: begin
                if (setup_q) begin
                    setup_d = 1'b0;
                end else begin
                    ctr_dec = 1'b1;
                    if (ctr_done_c) begin
                        if (!req_q.wr) begin
                            if (state_q == S_LO) begin
                                rd_data_d[BYTE_W-1:0] = ext_din;
                            end else begin
                                rd_data_d[DATA_W-1:BYTE_W] = ext_din;
                            end
                        end
                        if ((state_q == S_LO) && req_q.be1) begin
                            state_d = S_HI;
                            setup_d = 1'b1;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are computed from the next state so they register in step with it
        phase_d  = (state_d == S_LO) || (state_d == S_HI);
        strobe_d = phase_d && !setup_d;
        ctr_load = setup_d;
        if (phase_d) begin
            ext_addr_d = {word_d, (state_d == S_HI) ? LANE_HI : LANE_LO};
            ext_dout_d = (state_d == S_HI) ? req_d.data[DATA_W-1:BYTE_W] : req_d.data[BYTE_W-1:0];
        end
        cs_n_d    = !strobe_d;
        oe_n_d    = !(strobe_d && !req_d.wr);
        we_n_d    = !(strobe_d && req_d.wr);
        mem_rdy_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state_q    <= S_IDLE;
            setup_q    <= 1'b0;
            word_q     <= '0;
            req_q      <= '0;
            mem_rdy_q  <= 1'b0;
            rd_data_q  <= '0;
            ext_addr_q <= '0;
            ext_dout_q <= '0;
            cs_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            setup_q    <= setup_d;
            word_q     <= word_d;
            req_q      <= req_d;
            mem_rdy_q  <= mem_rdy_d;
            rd_data_q  <= rd_data_d;
            ext_addr_q <= ext_addr_d;
            ext_dout_q <= ext_dout_d;
            cs_n_q     <= cs_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
        end
    end

    assign mem_rdy  = mem_rdy_q;
    assign rd_data  = rd_data_q;
    assign ext_addr = ext_addr_q;
    assign ext_dout = ext_dout_q;
    assign ext_cs_n = cs_n_q;
    assign ext_oe_n = oe_n_q;
    assign ext_we_n = we_n_q;

    // ctr_zero is available for debug visibility; phase end uses ctr_done_c
    logic unused_ctr_zero;
    assign unused_ctr_zero = ctr_zero;

endmodule

// File: tb/tb_mem_bridge_8b.sv
// Bench for mem_bridge_8b: directed table, hand sequences and random traffic against an SRAM model.
// Build with MEM_BRIDGE_EXT_RDY_EN to also exercise the ext_rdy stretch.
module tb_mem_bridge_8b;

`ifdef MEM_BRIDGE_EXT_RDY_EN
    localparam int WS = 0;
`else
    localparam int WS = 1;
`endif

    logic        clk = 1'b0;
    logic        a_rst;
    logic        mem_assert, mem_cmd, be0, be1;
    logic [15:0] mem_addr, mem_data;
    logic        mem_rdy;
    logic [15:0] rd_data;
    logic [15:0] ext_addr;
    logic [7:0]  ext_dout, ext_din;
    logic        ext_cs_n, ext_oe_n, ext_we_n;
    logic        ext_rdy;

    always #5 clk = ~clk;

    mem_bridge_8b #(.WAIT_STATES(WS), .ADDR_W(16)) dut (
        .clk       (clk),
        .a_rst     (a_rst),
        .mem_assert(mem_assert),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_cmd   (mem_cmd),
        .be0       (be0),
        .be1       (be1),
        .mem_rdy   (mem_rdy),
        .rd_data   (rd_data),
        .ext_addr  (ext_addr),
        .ext_dout  (ext_dout),
        .ext_din   (ext_din),
`ifdef MEM_BRIDGE_EXT_RDY_EN
        .ext_rdy   (ext_rdy),
`endif
        .ext_cs_n  (ext_cs_n),
        .ext_oe_n  (ext_oe_n),
        .ext_we_n  (ext_we_n)
    );

    // External SRAM: unwritten bytes return a fixed address pattern
    logic [7:0]  sram   [0:65535];
    bit          wr_v   [0:65535];
    logic [7:0]  ref_mem[0:65535];
    bit          ref_v  [0:65535];
    logic [15:0] slog   [0:4095];
    int strobe_cnt = 0, bad_cnt = 0, rdy_cnt = 0;
    int stall_req = 0, stall_seen = 0;
    int n_chk = 0, n_fail = 0;

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    assign ext_rdy = !(stall_req > stall_seen);
    assign ext_din = !ext_rdy ? 8'hEE : (wr_v[ext_addr] ? sram[ext_addr] : pat(ext_addr));

    always @(negedge clk) begin
        if (a_rst) begin
            if (!ext_cs_n) begin
                slog[strobe_cnt[11:0]] <= ext_addr;
                strobe_cnt <= strobe_cnt + 1;
                if (!ext_we_n) begin
                    sram[ext_addr] <= ext_dout;
                    wr_v[ext_addr] <= 1'b1;
                end
                if (stall_seen < stall_req) stall_seen <= stall_seen + 1;
            end
            if (mem_rdy) rdy_cnt <= rdy_cnt + 1;
            if ((ext_cs_n && (!ext_oe_n || !ext_we_n)) || (!ext_oe_n && !ext_we_n))
                bad_cnt <= bad_cnt + 1;
        end
    end

    function automatic logic [7:0] ref_byte(input logic [15:0] a);
        return ref_v[a] ? ref_mem[a] : pat(a);
    endfunction

    function automatic logic [15:0] exp_read(input logic [15:0] a, input logic b0, input logic b1);
        logic [15:0] lo, hi;
        lo = {a[15:1], 1'b0};
        hi = {a[15:1], 1'b1};
        return {b1 ? ref_byte(hi) : 8'h00, b0 ? ref_byte(lo) : 8'h00};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Present a request; drop mem_assert and scramble the bus after `hold` edges
    task automatic issue(input logic cmd, input logic [15:0] addr, input logic [15:0] data,
                         input logic b0, input logic b1, input int hold,
                         output int lat, output logic [15:0] rd);
        mem_assert = 1'b1; mem_cmd = cmd; mem_addr = addr; mem_data = data; be0 = b0; be1 = b1;
        lat = -1;
        rd  = '0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (i == hold) begin
                mem_assert = 1'b0; mem_addr = 16'($urandom); mem_data = 16'($urandom);
                mem_cmd = ~cmd; be0 = ~b0; be1 = ~b1;
            end
            if (mem_rdy) begin
                lat = i;
                rd  = rd_data;
                break;
            end
        end
    endtask

    task automatic run_checked(input string tag, input logic cmd, input logic [15:0] addr,
                               input logic [15:0] data, input logic b0, input logic b1,
                               input int exp_lat, input logic [15:0] exp_rd, input bit chk_rd,
                               input int stretch);
        int lat, s0, bad0, r0, n;
        logic [15:0] rd;
        s0 = strobe_cnt; bad0 = bad_cnt; r0 = rdy_cnt;
        n = int'(b0) + int'(b1);
        issue(cmd, addr, data, b0, b1, 1, lat, rd);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " strobe_cycles"}, strobe_cnt - s0, n * (WS + 1) + stretch);
        if (n > 0) begin
            chk({tag, " first_ext_addr"}, slog[s0[11:0]], b0 ? {addr[15:1], 1'b0} : {addr[15:1], 1'b1});
            chk({tag, " last_ext_addr"}, slog[12'(strobe_cnt - 1)], b1 ? {addr[15:1], 1'b1} : {addr[15:1], 1'b0});
        end
        if (chk_rd) chk({tag, " rd_data"}, rd, exp_rd);
        @(posedge clk); #1;
        chk({tag, " rdy_width"}, mem_rdy, 0);
        chk({tag, " rdy_count"}, rdy_cnt - r0, 1);
        chk({tag, " strobe_protocol"}, bad_cnt - bad0, 0);
        if (cmd) begin
            if (b0) begin ref_mem[{addr[15:1], 1'b0}] = data[7:0];  ref_v[{addr[15:1], 1'b0}] = 1'b1; end
            if (b1) begin ref_mem[{addr[15:1], 1'b1}] = data[15:8]; ref_v[{addr[15:1], 1'b1}] = 1'b1; end
        end
    endtask

    typedef struct {
        logic        cmd;
        logic [15:0] addr;
        logic [15:0] data;
        logic        b0, b1;
        int          lat;
        logic [15:0] rd;
        bit          chk_rd;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int lat, r0, n, exp_lat;
        logic [15:0] rd, a, d;
        logic c, b0, b1;

        tbl[0]  = '{1'b1, 16'h1234, 16'h1234, 1'b1, 1'b1, 1 + 2 * (WS + 2), 16'h0000, 1'b0};
        tbl[1]  = '{1'b0, 16'h1234, 16'h0000, 1'b1, 1'b1, 1 + 2 * (WS + 2), 16'h1234, 1'b1};
        tbl[2]  = '{1'b1, 16'h1235, 16'hAB00, 1'b0, 1'b1, 1 + (WS + 2),     16'h0000, 1'b0};
        tbl[3]  = '{1'b0, 16'h1234, 16'h0000, 1'b1, 1'b1, 1 + 2 * (WS + 2), 16'hAB34, 1'b1};
        tbl[4]  = '{1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0, 1,                16'h0000, 1'b1};
        tbl[5]  = '{1'b1, 16'h2000, 16'h5AA5, 1'b1, 1'b1, 1 + 2 * (WS + 2), 16'h0000, 1'b0};
        tbl[6]  = '{1'b0, 16'h2001, 16'h0000, 1'b1, 1'b1, 1 + 2 * (WS + 2), 16'h5AA5, 1'b1};
        tbl[7]  = '{1'b0, 16'h2000, 16'h0000, 1'b1, 1'b0, 1 + (WS + 2),     16'h00A5, 1'b1};
        tbl[8]  = '{1'b0, 16'h2000, 16'h0000, 1'b0, 1'b1, 1 + (WS + 2),     16'h5A00, 1'b1};
        tbl[9]  = '{1'b1, 16'h2000, 16'hFFFF, 1'b0, 1'b0, 1,                16'h0000, 1'b0};
        tbl[10] = '{1'b0, 16'h2000, 16'h0000, 1'b1, 1'b1, 1 + 2 * (WS + 2), 16'h5AA5, 1'b1};

        a_rst = 1'b0; mem_assert = 1'b0; mem_cmd = 1'b0; mem_addr = '0; mem_data = '0;
        be0 = 1'b0; be1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset mem_rdy", mem_rdy, 0);
        chk("reset rd_data", rd_data, 0);
        chk("reset ext_addr", ext_addr, 0);
        chk("reset ext_dout", ext_dout, 0);
        chk("reset cs_n", ext_cs_n, 1);
        chk("reset oe_n", ext_oe_n, 1);
        chk("reset we_n", ext_we_n, 1);
        a_rst = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i])
            run_checked($sformatf("vec%0d", i), tbl[i].cmd, tbl[i].addr, tbl[i].data,
                        tbl[i].b0, tbl[i].b1, tbl[i].lat, tbl[i].rd, tbl[i].chk_rd, 0);

        // Back-to-back: second request presented during the DONE cycle of the first
        r0 = rdy_cnt;
        issue(1'b0, 16'h2000, 16'h0, 1'b1, 1'b1, 1, lat, rd);
        chk("b2b first latency", lat, 1 + 2 * (WS + 2));
        chk("b2b first rd_data", rd, 16'h5AA5);
        issue(1'b0, 16'h1234, 16'h0, 1'b1, 1'b1, 2, lat, rd);
        chk("b2b second latency", lat, 2 + 2 * (WS + 2));
        chk("b2b second rd_data", rd, 16'hAB34);
        repeat (5) @(posedge clk);
        #1;
        chk("b2b rdy_count", rdy_cnt - r0, 2);

        // Reset during the HI strobe aborts the read with no completion
        r0 = rdy_cnt;
        mem_assert = 1'b1; mem_cmd = 1'b0; mem_addr = 16'h1234; be0 = 1'b1; be1 = 1'b1;
        @(posedge clk); #1;
        mem_assert = 1'b0;
        repeat (WS + 3) @(posedge clk);
        #1;
        chk("abort hi strobe active", ext_cs_n, 0);
        chk("abort hi ext_addr", ext_addr, 16'h1235);
        #2;
        a_rst = 1'b0;
        #1;
        chk("abort cs_n", ext_cs_n, 1);
        chk("abort oe_n", ext_oe_n, 1);
        chk("abort mem_rdy", mem_rdy, 0);
        chk("abort rd_data", rd_data, 0);
        chk("abort ext_addr", ext_addr, 0);
        @(posedge clk); #3;
        a_rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("abort no rdy", rdy_cnt - r0, 0);
        run_checked("after_abort", 1'b0, 16'h1234, 16'h0, 1'b1, 1'b1, 1 + 2 * (WS + 2), 16'hAB34, 1'b1, 0);

`ifdef MEM_BRIDGE_EXT_RDY_EN
        // ext_rdy held low through three strobe-cycle edges stretches the phase by three
        stall_req = stall_seen + 4;
        run_checked("ext_rdy", 1'b0, 16'h2000, 16'h0, 1'b1, 1'b0, 1 + (WS + 2) + 3, 16'h00A5, 1'b1, 3);
`endif

        for (int i = 0; i < 40; i++) begin
            c  = 1'($urandom_range(0, 1));
            a  = 16'h0100 + 16'($urandom_range(0, 15));
            d  = 16'($urandom);
            b0 = 1'($urandom_range(0, 1));
            b1 = 1'($urandom_range(0, 1));
            n  = int'(b0) + int'(b1);
            exp_lat = 1 + n * (WS + 2);
            run_checked($sformatf("rand%0d", i), c, a, d, b0, b1, exp_lat, exp_read(a, b0, b1), !c, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1);
    end

endmodule
